// File: rtl/ps2_scancode_sequencer.sv
// Assembles PS/2 set-2 byte sequences into key codes for an external set-1 translator
// and serialises the translated bytes into a show-ahead FIFO for the CPU.
module ps2_scancode_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int E1_SKIP    = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    output logic [15:0]                   set2_key,
    output logic                          set2_break,
    input  logic [15:0]                   set1_key,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] EXT       = 3'd1;
    localparam logic [2:0] BRK       = 3'd2;
    localparam logic [2:0] EXT_BRK   = 3'd3;
    localparam logic [2:0] SKIP      = 3'd4;
    localparam logic [2:0] LOOKUP    = 3'd5;
    localparam logic [2:0] EMIT_PFX  = 3'd6;
    localparam logic [2:0] EMIT_CODE = 3'd7;

    logic [2:0]    state;
    logic [SW-1:0] skip_cnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [CW-1:0] free_slots;
    logic          room_ok;
    logic          busy;

    // Receiver status/ack bytes that never start a key sequence.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    assign push       = (state == EMIT_PFX) || (state == EMIT_CODE);
    assign push_data  = (state == EMIT_PFX) ? 8'hE0 : set1_key[7:0];
    assign empty      = (fifo_count == '0);
    assign pop        = rd_en && !empty;
    assign rd_data    = empty ? 8'h00 : mem[rd_ptr];
    assign busy       = (state == LOOKUP) || (state == EMIT_PFX) || (state == EMIT_CODE);
    // A pop in the LOOKUP cycle is deliberately not credited as free space.
    assign free_slots = CW'(FIFO_DEPTH) - fifo_count;
    assign room_ok    = (set1_key[15:8] == 8'hE0) ? (free_slots >= CW'(2))
                                                  : (free_slots >= CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            set2_key   <= 16'h0000;
            set2_break <= 1'b0;
            skip_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (rx_valid && busy)
                overflow <= 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    if (rx_byte == 8'hE0) begin
                        state <= EXT;
                    end else if (rx_byte == 8'hF0) begin
                        state <= BRK;
                    end else if (rx_byte == 8'hE1) begin
                        state    <= SKIP;
                        skip_cnt <= SW'(E1_SKIP);
                    end else if (!is_discard(rx_byte)) begin
                        set2_key   <= {8'h00, rx_byte};
                        set2_break <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                EXT: if (rx_valid) begin
                    if (rx_byte == 8'hF0) begin
                        state <= EXT_BRK;
                    end else if (rx_byte != 8'hE0) begin
                        set2_key   <= {8'hE0, rx_byte};
                        set2_break <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                BRK: if (rx_valid) begin
                    set2_key   <= {8'h00, rx_byte};
                    set2_break <= 1'b1;
                    state      <= LOOKUP;
                end
                EXT_BRK: if (rx_valid) begin
                    set2_key   <= {8'hE0, rx_byte};
                    set2_break <= 1'b1;
                    state      <= LOOKUP;
                end
                SKIP: if (rx_valid) begin
                    skip_cnt <= skip_cnt - SW'(1);
                    if (skip_cnt == SW'(1))
                        state <= IDLE;
                end
                LOOKUP: begin
                    if (set1_key[6:0] == 7'd0) begin
                        state <= IDLE;
                    end else if (!room_ok) begin
                        overflow <= 1'b1;
                        state    <= IDLE;
                    end else if (set1_key[15:8] == 8'hE0) begin
                        state <= EMIT_PFX;
                    end else begin
                        state <= EMIT_CODE;
                    end
                end
                EMIT_PFX:  state <= EMIT_CODE;
                EMIT_CODE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // FIFO control; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for ps2_scancode_sequencer with a small set-2 to set-1 translator model.
module tb_ps2_scancode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] set2_key;
    logic        set2_break;
    logic [15:0] set1_key;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        empty;
    logic [4:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ps2_scancode_sequencer #(.FIFO_DEPTH(16), .E1_SKIP(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .set2_key   (set2_key),
        .set2_break (set2_break),
        .set1_key   (set1_key),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Translator: a handful of keys; anything else is unsupported (zero).
    always_comb begin
        logic [15:0] base;
        case (set2_key)
            16'h001C: base = 16'h001E;
            16'h0016: base = 16'h0002;
            16'h0075: base = 16'h0048;
            16'hE075: base = 16'hE048;
            default:  base = 16'h0000;
        endcase
        set1_key = (base == 16'h0000) ? 16'h0000 : (base | {8'h00, set2_break, 7'h00});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = rd_data;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (set2_key !== 16'h0000 || set2_break !== 1'b0) begin
            errors++;
            $display("FAIL reset_set2: got %h/%b want 0000/0", set2_key, set2_break);
        end
        checks++;
        if (empty !== 1'b1 || fifo_count !== 5'd0 || rd_data !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo: empty=%b count=%0d rd=%h ovf=%b want 1/0/00/0",
                     empty, fifo_count, rd_data, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_key();
        logic [7:0] b;
        pulse_reset();
        send(8'h1C);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL lat_edge0: empty=%b want 1", empty); end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL lat_edge1: empty=%b want 1", empty); end
        @(negedge clk);
        checks++;
        if (empty !== 1'b0 || rd_data !== 8'h1E) begin
            errors++;
            $display("FAIL lat_edge2: empty=%b rd=%h want 0/1E", empty, rd_data);
        end
        settle();
        send(8'hF0);
        send(8'h1C);
        settle();
        checks++;
        if (fifo_count !== 5'd2) begin errors++; $display("FAIL break_count: got %0d want 2", fifo_count); end
        pop_byte(b);
        checks++;
        if (b !== 8'h1E || rd_data !== 8'h9E) begin
            errors++;
            $display("FAIL break_byte: got %h,%h want 1E,9E", b, rd_data);
        end
        pop_byte(b);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || fifo_count !== 5'd0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL pop_empty: empty=%b count=%0d rd=%h want 1/0/00", empty, fifo_count, rd_data);
        end
    endtask

    task automatic test_extended();
        logic [7:0] b0, b1;
        pulse_reset();
        send(8'hE0);
        send(8'h75);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'hE0) begin
            errors++;
            $display("FAIL ext_prefix_first: count=%0d rd=%h want 1/E0", fifo_count, rd_data);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 5'd2 || set2_key !== 16'hE075 || set2_break !== 1'b0) begin
            errors++;
            $display("FAIL ext_second: count=%0d key=%h brk=%b want 2/E075/0", fifo_count, set2_key, set2_break);
        end
        settle();
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        settle();
        pop_byte(b0);
        pop_byte(b1);
        checks++;
        if (b0 !== 8'hE0 || b1 !== 8'h48) begin
            errors++;
            $display("FAIL ext_make: got %h,%h want E0,48", b0, b1);
        end
        pop_byte(b0);
        pop_byte(b1);
        checks++;
        if (b0 !== 8'hE0 || b1 !== 8'hC8 || set2_break !== 1'b1) begin
            errors++;
            $display("FAIL ext_break: got %h,%h brk=%b want E0,C8,1", b0, b1, set2_break);
        end
    endtask

    task automatic test_pause_skip();
        logic [7:0] seq [9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        pulse_reset();
        for (int i = 0; i < 9; i++) send(seq[i]);
        settle();
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'h02 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL pause_skip: count=%0d rd=%h ovf=%b want 1/02/0", fifo_count, rd_data, overflow);
        end
    endtask

    task automatic test_unsupported();
        pulse_reset();
        send(8'h16);
        settle();
        send(8'hE0);
        send(8'h12);
        settle();
        checks++;
        if (fifo_count !== 5'd1 || set2_key !== 16'hE012) begin
            errors++;
            $display("FAIL unsupported: count=%0d key=%h want 1/E012", fifo_count, set2_key);
        end
        send(8'hAA);
        send(8'hFA);
        settle();
        checks++;
        if (fifo_count !== 5'd1 || set2_key !== 16'hE012 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL discard_bytes: count=%0d key=%h ovf=%b want 1/E012/0", fifo_count, set2_key, overflow);
        end
    endtask

    task automatic test_full();
        logic [7:0] b;
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            send(8'h1C);
            settle();
        end
        checks++;
        if (fifo_count !== 5'd15 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill15: count=%0d ovf=%b want 15/0", fifo_count, overflow);
        end
        send(8'hE0);
        send(8'h75);
        settle();
        checks++;
        if (fifo_count !== 5'd15 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL no_split: count=%0d ovf=%b want 15/1", fifo_count, overflow);
        end
        send(8'h1C);
        settle();
        checks++;
        if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill16: count=%0d want 16", fifo_count); end
        send(8'h1C);
        settle();
        checks++;
        if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_drop: count=%0d want 16", fifo_count); end
        pop_byte(b);
        send(8'h16);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (fifo_count !== 5'd15) begin
            errors++;
            $display("FAIL push_pop_same_edge: count=%0d want 15", fifo_count);
        end
        for (int i = 0; i < 14; i++) pop_byte(b);
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'h02) begin
            errors++;
            $display("FAIL wrap_order: count=%0d rd=%h want 1/02", fifo_count, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        send(8'h1C);
        send(8'h16);
        settle();
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'h1E || overflow !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop: count=%0d rd=%h ovf=%b want 1/1E/1", fifo_count, rd_data, overflow);
        end
    endtask

    task automatic test_reset_mid_sequence();
        pulse_reset();
        send(8'hE0);
        pulse_reset();
        send(8'h1C);
        settle();
        checks++;
        if (fifo_count !== 5'd1 || rd_data !== 8'h1E || overflow !== 1'b0 || set2_key !== 16'h001C) begin
            errors++;
            $display("FAIL reset_mid: count=%0d rd=%h ovf=%b key=%h want 1/1E/0/001C",
                     fifo_count, rd_data, overflow, set2_key);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_extended();
        test_pause_skip();
        test_unsupported();
        test_full();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
